// File: rtl/bios_port_arbiter.sv
// Single-port BIOS memory arbiter between instruction fetch and data access, with read-latency
// tracking and return steering. Define BIOS_ARB_STARVE_GUARD_EN to enable the fetch starvation guard.
module bios_port_arbiter #(
    parameter int unsigned RD_LATENCY   = 2,
    parameter int unsigned MAX_DATA_RUN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [11:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        d_stall
);

    typedef enum logic [1:0] {StIdle, StRdIf, StRdD} state_e;

    state_e     state_q;
    logic [2:0] lat_cnt_q;
    logic       ret;
    logic       issue_ok;
    logic       starve;
    logic       d_win;
    logic       if_win;
    logic       d_read;
    logic       unused_addr;

    assign unused_addr = ^{if_addr[31:14], if_addr[1:0], d_addr[31:14], d_addr[1:0]};

    // Return cycle doubles as an issue slot so reads can go back-to-back.
    assign ret      = (state_q != StIdle) && (lat_cnt_q == 3'd1);
    assign issue_ok = rst && ((state_q == StIdle) || ret);

`ifdef BIOS_ARB_STARVE_GUARD_EN
    logic [3:0] run_cnt_q;

    assign starve = if_req && (run_cnt_q == 4'(MAX_DATA_RUN));

    always_ff @(posedge clk) begin
        if (!rst || !if_req || if_win) begin
            run_cnt_q <= 4'd0;
        end else if (d_win && (run_cnt_q != 4'(MAX_DATA_RUN))) begin
            run_cnt_q <= run_cnt_q + 4'd1;
        end
    end
`else
    localparam int unsigned unused_max_run = MAX_DATA_RUN;

    assign starve = 1'b0;
`endif

    assign d_win  = issue_ok && d_req && !starve;
    assign if_win = issue_ok && if_req && !d_win;
    assign d_read = d_win && (d_we == 4'd0);

    always_comb begin
        if_gnt    = if_win;
        d_gnt     = d_win;
        mem_en    = if_win || d_win;
        mem_we    = d_win ? d_we : 4'd0;
        mem_wdata = d_win ? d_wdata : 32'd0;
        if (d_win) begin
            mem_addr = d_addr[13:2];
        end else if (if_win) begin
            mem_addr = if_addr[13:2];
        end else begin
            mem_addr = 12'd0;
        end
        // Steer by the owner recorded at issue, not by the current winner.
        if_rvalid = rst && ret && (state_q == StRdIf);
        d_rvalid  = rst && ret && (state_q == StRdD);
        if_rdata  = if_rvalid ? mem_rdata : 32'd0;
        d_rdata   = d_rvalid ? mem_rdata : 32'd0;
        d_stall   = rst && ((d_req && !d_win) || ((state_q == StRdD) && !ret));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            lat_cnt_q <= 3'd0;
        end else if (d_read) begin
            state_q   <= StRdD;
            lat_cnt_q <= 3'(RD_LATENCY);
        end else if (if_win) begin
            state_q   <= StRdIf;
            lat_cnt_q <= 3'(RD_LATENCY);
        end else if (ret || d_win) begin
            state_q   <= StIdle;
            lat_cnt_q <= 3'd0;
        end else if (state_q != StIdle) begin
            lat_cnt_q <= lat_cnt_q - 3'd1;
        end
    end

endmodule
